// File: rtl/bit_scan_pkg.sv
// Shared types for the bit-scan encoder: FSM state encoding and its width.
package bit_scan_pkg;

    localparam int unsigned STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/bit_scan_pri_enc.sv
// Combinational priority encoder: index of the winning set bit plus an any-set flag.
// Priority is LSB-first unless BIT_SCAN_MSB_FIRST_EN is defined (then MSB-first).
module bit_scan_pri_enc #(
    parameter int unsigned m = 3,
    parameter int unsigned n = 1 << m
) (
    input  logic [n-1:0] vec,
    output logic [m-1:0] idx,
    output logic         any_set
);

    // Later loop iterations overwrite earlier ones, so the scan order picks the winner.
    always_comb begin
        idx     = '0;
        any_set = |vec;
`ifdef BIT_SCAN_MSB_FIRST_EN
        for (int i = 0; i < int'(n); i++) begin
            if (vec[i]) idx = m'(i);
        end
`else
        for (int i = int'(n) - 1; i >= 0; i--) begin
            if (vec[i]) idx = m'(i);
        end
`endif
    end

endmodule

// File: rtl/bit_scan_encoder.sv
// Accepts a request vector and emits the index of each set bit, one per handshake.
// Scan order follows bit_scan_pri_enc (BIT_SCAN_MSB_FIRST_EN selects MSB-first).
module bit_scan_encoder
    import bit_scan_pkg::*;
#(
    parameter int unsigned m = 3,
    parameter int unsigned n = 1 << m
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] recv_msg,
    input  logic         recv_val,
    output logic         recv_rdy,
    output logic [m-1:0] send_msg,
    output logic         send_val,
    input  logic         send_rdy,
    output logic         send_last
);

    state_e         state_q, state_d;
    logic [n-1:0]   vec_q, vec_d;
    logic [m-1:0]   pri_idx;
    logic           pri_any;
    logic           one_left;

    bit_scan_pri_enc #(
        .m (m),
        .n (n)
    ) u_pri_enc (
        .vec     (vec_q),
        .idx     (pri_idx),
        .any_set (pri_any)
    );

    // Exactly one bit remains: nonzero with its lowest set bit cleared giving zero.
    assign one_left = pri_any && ((vec_q & (vec_q - n'(1))) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            IDLE: begin
                if (recv_val) begin
                    vec_d = recv_msg;
                    if (recv_msg != '0) state_d = SCAN;
                end
            end
            SCAN: begin
                if (send_rdy) begin
                    vec_d = vec_q & ~(n'(1) << pri_idx);
                    if (one_left) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

    always_comb begin
        recv_rdy  = (state_q == IDLE);
        send_val  = (state_q == SCAN);
        send_msg  = (state_q == SCAN) ? pri_idx : '0;
        send_last = (state_q == SCAN) && one_left;
    end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Directed-vector bench for bit_scan_encoder (m=3) with a queue-based reference model.
// Expectations follow BIT_SCAN_MSB_FIRST_EN when it is defined.
module tb_bit_scan_encoder;

    localparam int unsigned M = 3;
    localparam int unsigned N = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] recv_msg;
    logic         recv_val;
    logic         recv_rdy;
    logic [M-1:0] send_msg;
    logic         send_val;
    logic         send_rdy;
    logic         send_last;

    int checks   = 0;
    int failures = 0;

    bit m_busy = 1'b0;
    int m_q[$];
    int obs_idx[$];
    int obs_last[$];

    bit_scan_encoder #(
        .m (M),
        .n (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .recv_msg  (recv_msg),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .send_msg  (send_msg),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .send_last (send_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted vector becomes a queue of indices in emission order.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_q.delete();
        end else if (m_busy) begin
            if (send_rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 1'b0;
            end
        end else if (recv_val) begin
            m_q.delete();
`ifdef BIT_SCAN_MSB_FIRST_EN
            for (int i = N - 1; i >= 0; i--) if (recv_msg[i]) m_q.push_back(i);
`else
            for (int i = 0; i < N; i++) if (recv_msg[i]) m_q.push_back(i);
`endif
            m_busy = (m_q.size() > 0);
        end
    end

    // Per-cycle compare against the model, and log of completed transfers.
    always @(negedge clk) begin
        chk("recv_rdy", int'(recv_rdy), int'(!m_busy));
        chk("send_val", int'(send_val), int'(m_busy));
        chk("send_msg", int'(send_msg), m_busy ? m_q[0] : 0);
        chk("send_last", int'(send_last), int'(m_busy && m_q.size() == 1));
        if (send_val && send_rdy) begin
            obs_idx.push_back(int'(send_msg));
            obs_last.push_back(int'(send_last));
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_vec(input logic [N-1:0] v);
        recv_msg = v;
        recv_val = 1'b1;
        step(1);
        recv_val = 1'b0;
        recv_msg = '0;
    endtask

    task automatic chk_obs(input string name, input int exp_idx[$], input int exp_last[$]);
        chk({name, "_count"}, obs_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size(); i++) begin
            chk({name, "_idx"}, (i < obs_idx.size()) ? obs_idx[i] : -1, exp_idx[i]);
            chk({name, "_last"}, (i < obs_last.size()) ? obs_last[i] : -1, exp_last[i]);
        end
        obs_idx.delete();
        obs_last.delete();
    endtask

    initial begin
        int e_idx[$];
        int e_last[$];
        reset    = 1'b1;
        recv_msg = '0;
        recv_val = 1'b0;
        send_rdy = 1'b1;
        step(2);
        chk("rst_recv_rdy", int'(recv_rdy), 1);
        chk("rst_send_val", int'(send_val), 0);
        chk("rst_send_msg", int'(send_msg), 0);
        chk("rst_send_last", int'(send_last), 0);
        reset = 1'b0;
        step(1);

        // Three set bits, no backpressure.
        send_vec(8'b1010_0100);
        chk("a5_first_val", int'(send_val), 1);
        step(4);
        chk("a5_rdy_after", int'(recv_rdy), 1);
`ifdef BIT_SCAN_MSB_FIRST_EN
        e_idx = '{7, 5, 2};
`else
        e_idx = '{2, 5, 7};
`endif
        e_last = '{0, 0, 1};
        chk_obs("a5", e_idx, e_last);

        // Empty vector produces nothing.
        send_vec(8'h00);
        chk("zero_rdy", int'(recv_rdy), 1);
        chk("zero_val", int'(send_val), 0);
        step(3);
        e_idx.delete();
        e_last.delete();
        chk_obs("zero", e_idx, e_last);

        // Backpressure holds the first index.
        send_rdy = 1'b0;
        send_vec(8'b0001_0001);
        for (int c = 0; c < 3; c++) begin
`ifdef BIT_SCAN_MSB_FIRST_EN
            chk("bp_hold_msg", int'(send_msg), 4);
`else
            chk("bp_hold_msg", int'(send_msg), 0);
`endif
            chk("bp_hold_val", int'(send_val), 1);
            step(1);
        end
        send_rdy = 1'b1;
        step(4);
`ifdef BIT_SCAN_MSB_FIRST_EN
        e_idx = '{4, 0};
`else
        e_idx = '{0, 4};
`endif
        e_last = '{0, 1};
        chk_obs("bp", e_idx, e_last);

        // All ones: full sweep, recv_rdy low throughout.
        send_vec(8'hFF);
        for (int c = 0; c < 8; c++) begin
            chk("ff_rdy_low", int'(recv_rdy), 0);
            step(1);
        end
        step(2);
        e_idx.delete();
        e_last.delete();
        for (int i = 0; i < 8; i++) begin
`ifdef BIT_SCAN_MSB_FIRST_EN
            e_idx.push_back(7 - i);
`else
            e_idx.push_back(i);
`endif
            e_last.push_back((i == 7) ? 1 : 0);
        end
        chk_obs("ff", e_idx, e_last);

        // Reset mid-scan discards the remaining indices.
        send_vec(8'b1100_0100);
        step(1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rdy", int'(recv_rdy), 1);
        chk("mid_rst_val", int'(send_val), 0);
        chk("mid_rst_msg", int'(send_msg), 0);
        chk("mid_rst_last", int'(send_last), 0);
        step(2);
        reset = 1'b0;
        step(5);
`ifdef BIT_SCAN_MSB_FIRST_EN
        e_idx = '{7};
`else
        e_idx = '{2};
`endif
        e_last = '{0};
        chk_obs("mid_rst", e_idx, e_last);

        // Back-to-back vectors with a single separating IDLE cycle.
        send_vec(8'b0000_0010);
        chk("b2b_idle_rdy", int'(recv_rdy), 0);
        step(1);
        send_vec(8'b1000_0000);
        step(2);
        e_idx = '{1, 7};
        e_last = '{1, 1};
        chk_obs("b2b", e_idx, e_last);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
